// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and hazard controller for a 5-stage RV32IMC pipeline. It sits
// beside the ID/EX pipeline register and shadows the destination-register
// information of the instructions currently in EX, MEM and WB. From that it
// derives, while an instruction is still in ID, the operand-select codes that
// the EX-stage 4:1 operand muxes will use one cycle later. It also raises the
// load-use and mul/div-busy stalls and turns flushed or stalled slots into
// bubbles.
//
// Parameters:
//   REG_AW       register-address width
//
// Ports:
//   clk          pipeline clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   id_valid     ID slot holds a real instruction
//   id_rs1/2     source registers of the ID instruction
//   id_rd        destination register of the ID instruction
//   id_regwrite  ID instruction writes rd
//   id_memread   ID instruction is a load
//   id_link      ID instruction is JAL/JALR (result is PC+4)
//   flush        taken branch/jump resolved in EX, kill the ID instruction
//   md_start     mul/div unit starts a multi-cycle op this cycle
//   md_done      mul/div result ready (pulse)
//   fwd_a_sel    EX operand A select (00 RF, 01 EX/MEM ALU, 10 MEM/WB, 11 link)
//   fwd_b_sel    EX operand B select, same encoding
//   stall        combinational, hold PC and IF/ID
//   bubble_ex    registered, EX slot holds a bubble this cycle
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_link,
    input  logic              flush,
    input  logic              md_start,
    input  logic              md_done,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              bubble_ex
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;
    localparam logic [1:0] SEL_LINK = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              link;
    } entry_t;

    // Tracking entries for the instructions in EX (e), MEM (m) and WB (w).
    entry_t e_q, e_d;
    entry_t m_q, m_d;
    entry_t w_q, w_d;

    logic       md_busy_q, md_busy_d;
    logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0] fwd_b_sel_q, fwd_b_sel_d;
    logic       bubble_ex_q, bubble_ex_d;

    logic [1:0] sel_a_calc;
    logic [1:0] sel_b_calc;
    logic       load_use;
    logic       stall_int;
    logic       e_valid_new;

    // An entry produces register r only if it is live, writes back, and r is
    // not x0 (x0 producers must never forward or stall).
    function automatic logic entry_writes(input entry_t ent,
                                          input logic [REG_AW-1:0] r);
        return ent.valid && ent.regwrite && (ent.rd == r) && (r != '0);
    endfunction

    // -------------------------------------------------------------------------
    // Per-source select and load-use detection.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [REG_AW-1:0] rs;
            logic [1:0]        sel;
            logic              load_hit;

            assign rs = (gi == 0) ? id_rs1 : id_rs2;

            always_comb begin
                sel      = SEL_RF;
                load_hit = 1'b0;
                // The E entry is one stage younger than M, so it is checked
                // first: the youngest producer of rs supplies the value.
                if (entry_writes(e_q, rs)) begin
                    if (e_q.memread) begin
                        // Load data is not available yet: stall instead.
                        load_hit = 1'b1;
                    end else if (e_q.link) begin
                        sel = SEL_LINK;
                    end else begin
                        sel = SEL_ALU;
                    end
                end else if (entry_writes(m_q, rs)) begin
                    sel = SEL_WB;
                end
                // A W-stage producer is covered by register-file write-through.
            end
        end
    endgenerate

    assign sel_a_calc = g_src[0].sel;
    assign sel_b_calc = g_src[1].sel;
    assign load_use   = id_valid && (g_src[0].load_hit || g_src[1].load_hit);

    // md_start stalls combinationally in its own cycle, before md_busy is set.
    assign stall_int   = load_use || md_busy_q || md_start;
    // flush wins over stall; either one turns the next EX slot into a bubble.
    assign e_valid_new = id_valid && !stall_int && !flush;

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        // md_done in the same cycle as md_start means a single-cycle op.
        md_busy_d   = (md_busy_q || md_start) && !md_done;

        e_d         = e_q;
        m_d         = m_q;
        w_d         = w_q;
        fwd_a_sel_d = fwd_a_sel_q;
        fwd_b_sel_d = fwd_b_sel_q;
        bubble_ex_d = bubble_ex_q;

        // While the mul/div unit is busy, EX is frozen and everything holds;
        // a flush can not arrive then because no branch resolves in EX.
        if (!md_busy_q) begin
            w_d          = m_q;
            m_d          = e_q;
            e_d.valid    = e_valid_new;
            e_d.rd       = id_rd;
            e_d.regwrite = id_regwrite;
            e_d.memread  = id_memread;
            e_d.link     = id_link;
            fwd_a_sel_d  = e_valid_new ? sel_a_calc : SEL_RF;
            fwd_b_sel_d  = e_valid_new ? sel_b_calc : SEL_RF;
            bubble_ex_d  = !e_valid_new;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            md_busy_q   <= 1'b0;
            fwd_a_sel_q <= SEL_RF;
            fwd_b_sel_q <= SEL_RF;
            bubble_ex_q <= 1'b1;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            md_busy_q   <= md_busy_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            bubble_ex_q <= bubble_ex_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
    assign bubble_ex = bubble_ex_q;
    assign stall     = stall_int;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       id_link;
    logic       flush;
    logic       md_start;
    logic       md_done;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       bubble_ex;

    int tests_run = 0;
    int tests_failed = 0;

    fwd_hazard_ctrl #(.REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_link     (id_link),
        .flush       (flush),
        .md_start    (md_start),
        .md_done     (md_done),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .bubble_ex   (bubble_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic lk);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_link     = lk;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        md_start = 1'b0;
        md_done = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- Reset state ----------------
        #2;
        check("rst_fwd_a", fwd_a_sel, 2'b00);
        check("rst_fwd_b", fwd_b_sel, 2'b00);
        check("rst_bubble", bubble_ex, 1'b1);
        check("rst_stall", stall, 1'b0);
        md_start = 1'b1;
        #1;
        check("rst_stall_mdstart", stall, 1'b1);
        md_start = 1'b0;
        tick();
        rst = 1'b0;

        // ---------------- Back-to-back ALU dependency ----------------
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5,x1,x2
        #1; check("b2b_stall0", stall, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0);   // sub x6,x5,x7
        #1; check("b2b_stall1", stall, 1'b0);
        tick();
        check("b2b_fwd_a", fwd_a_sel, 2'b01);
        check("b2b_fwd_b", fwd_b_sel, 2'b00);
        check("b2b_bubble", bubble_ex, 1'b0);

        // ---------------- Distance-2 dependency ----------------
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);   // nop
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);   // or x8,x5,x5
        tick();
        check("d2_fwd_a", fwd_a_sel, 2'b10);
        check("d2_fwd_b", fwd_b_sel, 2'b10);

        // ---------------- Priority: E over M ----------------
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5 again
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);   // use x5
        tick();
        check("prio_fwd_a", fwd_a_sel, 2'b01);
        check("prio_fwd_b", fwd_b_sel, 2'b01);

        // ---------------- Load-use ----------------
        set_id(1'b1, 5'd2, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);   // lw x9
        tick();
        set_id(1'b1, 5'd9, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0);  // add x10,x9,x1
        #1; check("lu_stall", stall, 1'b1);
        tick();
        check("lu_bubble", bubble_ex, 1'b1);
        check("lu_bubble_fwd_a", fwd_a_sel, 2'b00);
        check("lu_stall_after", stall, 1'b0);
        tick();
        check("lu_add_bubble", bubble_ex, 1'b0);
        check("lu_add_fwd_a", fwd_a_sel, 2'b10);
        check("lu_add_fwd_b", fwd_b_sel, 2'b00);

        // ---------------- Link forwarding ----------------
        set_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1);   // jal x1
        tick();
        set_id(1'b1, 5'd1, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);  // use x1
        tick();
        check("link_fwd_a", fwd_a_sel, 2'b11);
        check("link_fwd_b", fwd_b_sel, 2'b00);

        // ---------------- x0 producer ----------------
        set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);  // use x0
        #1; check("x0_stall", stall, 1'b0);
        tick();
        check("x0_bubble", bubble_ex, 1'b0);
        check("x0_fwd_a", fwd_a_sel, 2'b00);

        // ---------------- Mul/div busy ----------------
        set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0);  // add x12
        tick();
        set_id(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0); // dependent on x12
        md_start = 1'b1;                                    // cycle t
        #1; check("md_stall_t", stall, 1'b1);
        tick();
        md_start = 1'b0;
        check("md_bubble_t1", bubble_ex, 1'b1);
        for (int i = 1; i <= 3; i++) begin                  // t+1 .. t+3
            #1; check($sformatf("md_stall_t%0d", i), stall, 1'b1);
            tick();
        end
        md_done = 1'b1;                                     // t+4
        #1; check("md_stall_t4", stall, 1'b1);
        check("md_frozen_fwd_a", fwd_a_sel, 2'b00);
        tick();
        md_done = 1'b0;                                     // t+5
        #1; check("md_stall_t5", stall, 1'b0);
        check("md_bubble_t5", bubble_ex, 1'b1);
        tick();
        check("md_adv_bubble", bubble_ex, 1'b0);
        check("md_adv_fwd_a", fwd_a_sel, 2'b10);

        // ---------------- Flush ----------------
        set_id(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);  // independent instr
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_bubble", bubble_ex, 1'b1);
        set_id(1'b1, 5'd2, 5'd0, 5'd14, 1'b1, 1'b1, 1'b0);  // lw x14
        tick();
        set_id(1'b1, 5'd14, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0); // dependent, flushed
        flush = 1'b1;
        #1; check("flush_lu_stall", stall, 1'b1);
        tick();
        flush = 1'b0;
        check("flush_lu_bubble", bubble_ex, 1'b1);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("flush_lu_never_in_e", bubble_ex, 1'b1);

        // ---------------- Reset mid load-use stall ----------------
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);   // lw x9,(x5)
        tick();
        check("pre_rst_fwd_a", fwd_a_sel, 2'b01);
        check("pre_rst_bubble", bubble_ex, 1'b0);
        set_id(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);  // use x9
        #1; check("pre_rst_stall", stall, 1'b1);
        #1; rst = 1'b1;
        #1;
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_fwd_a", fwd_a_sel, 2'b00);
        check("async_rst_bubble", bubble_ex, 1'b1);
        tick();
        rst = 1'b0;

        // ---------------- Reset mid mul/div stall ----------------
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        #1; check("md_busy_stall", stall, 1'b1);
        #1; rst = 1'b1;
        #1; check("md_rst_stall", stall, 1'b0);
        tick();
        rst = 1'b0;
        set_id(1'b1, 5'd5, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0);   // tracking empty
        #1; check("post_rst_stall", stall, 1'b0);
        tick();
        check("post_rst_bubble", bubble_ex, 1'b0);
        check("post_rst_fwd_a", fwd_a_sel, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

- Sequential forwarding and hazard controller for the 5-stage RV32IMC pipeline.
- Tracks the destination register of every instruction in EX, MEM and WB, and produces the 2-bit operand-select codes for the two EX-stage operand 4:1 muxes.
- Raises load-use and multiply/divide-busy stalls, and converts flushed or stalled slots into bubbles.
- Sits beside the ID/EX pipeline register; its select outputs are registered so they are stable for the whole EX cycle.

## Interface
Parameters:
- REG_AW, 5, register-address width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID slot holds a real instruction.
- id_rs1, id_rs2  input  REG_AW  source registers of the ID instruction.
- id_rd  input  REG_AW  destination register of the ID instruction.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- id_link  input  1  ID instruction is JAL/JALR; its result is PC+4.
- flush  input  1  branch/jump resolved taken in EX; kill the ID instruction.
- md_start  input  1  mul/div unit starts a multi-cycle op this cycle.
- md_done  input  1  mul/div result is ready; pulse.
- fwd_a_sel, fwd_b_sel  output  2  EX operand select:
  - 00 = register-file value
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB write-back data
  - 11 = EX/MEM link value (PC+4)
- stall  output  1  hold PC and IF/ID; combinational.
- bubble_ex  output  1  registered; EX slot holds a bubble this cycle.

## Operation
Tracking entries:
- Three entries, E (in EX), M (in MEM) and W (in WB).
- Each entry stores: valid, rd, regwrite, memread, link.
- An entry "writes r" when valid && regwrite && rd == r && r != 0.

Stall (combinational), asserted when either holds:
- Load-use: id_valid and E is a load (memread) writing id_rs1 or id_rs2.
- md_busy = 1, or md_start = 1 this cycle.

md_busy:
- Set on md_start; cleared on md_done.
- md_start and md_done in the same cycle: md_busy = 0 (single-cycle op).

Select computation, per source rs, at the ID stage:
- rs == 0: 00.
- Else if E writes rs and E.link: 11.
- Else if E writes rs (non-load): 01.
- Else if M writes rs: 10.
- Otherwise 00. A W match resolves through the register file's write-through, so it also gives 00.
- Priority is E over M: the youngest producer wins.

Clock-edge update when not md_busy:
- M <= E, W <= M.
- E <= ID fields, with valid = id_valid && !stall && !flush.
- fwd_*_sel <= computed selects, or 00 if the slot becomes a bubble.
- bubble_ex <= !(new E.valid).

Clock-edge update when md_busy:
- E, M, W and the selects hold.
- bubble_ex holds.

Flush and stall interaction:
- flush has priority over stall: a flushed instruction never enters E.
- flush during md_busy is ignored; the branch cannot resolve while EX is frozen.

## Timing
- Select latency: one cycle. Codes computed while the instruction is in ID appear on fwd_*_sel during its EX cycle.
- Load-use: exactly one bubble. The dependent instruction enters EX one cycle later with select 10.
- Mul/div: stall rises in the md_start cycle. It falls in the cycle after md_done, when md_busy has cleared and the dependent instruction advances.
- Reset (async, immediate):
  - all entries invalid, md_busy = 0
  - fwd_a_sel = fwd_b_sel = 00
  - bubble_ex = 1
  - stall = 0 unless md_start is asserted
- Reset mid-stall: the stall is abandoned and tracking restarts empty.
- rd = x0 producers never forward and never cause a stall.

## Test plan
- Back-to-back ALU dependency: add x5 followed by sub x6,x5,x7 -> fwd_a_sel = 01 in sub's EX cycle, fwd_b_sel = 00, stall never asserted.
- Distance-2 dependency plus priority:
  - add x5; nop; or x8,x5,x5 -> fwd_a_sel = fwd_b_sel = 10.
  - Two producers of x5 in E and M -> select 01.
- Load-use: lw x9 followed by add x10,x9,x1 -> stall = 1 for one cycle, bubble_ex = 1 next cycle, then add's EX cycle has fwd_a_sel = 10.
- Link forwarding and x0:
  - jal x1 followed by use of x1 -> select 11.
  - lw x0 followed by use of x0 -> no stall, select 00.
- Mul/div: md_start at cycle t, md_done at t+4 -> stall high from t through t+4, E/M/W and selects frozen, pipeline advances at t+5.
- Flush and reset:
  - flush together with a load-use stall -> next cycle bubble_ex = 1 and the killed instruction never appears in E.
  - rst asserted mid-stall -> all outputs go to reset values immediately, without waiting for a clock edge.
